// File: rtl/definitions_pkg.sv
// Shared chip-level constants and types; the frame-sequencer entries cover image
// geometry, the command sync pattern, the flush bound and the error-flag bit positions.
package definitions_pkg;

  localparam int FIFO_WIDTH = 8;

  localparam int IMG_W     = 64;
  localparam int IMG_H     = 64;
  localparam int TOTAL_PIX = IMG_W * IMG_H;
  localparam int FLUSH_MAX = 2 * IMG_W + 16;

  // Upper five bits of a byte that marks it as a frame command.
  localparam logic [4:0] CMD_SYNC = 5'b10100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  localparam int ERR_RX_DROP  = 0;
  localparam int ERR_FLUSH_TO = 1;
  localparam int ERR_TX_DROP  = 2;

endpackage

// File: rtl/frame_sequencer.sv
// Frame controller: decodes the command byte, feeds one frame into the pixel
// pipeline, flushes it with zero pixels and forwards one frame of results to UART TX.
module frame_sequencer
  import definitions_pkg::*;
#(
  parameter int DATA_W    = definitions_pkg::FIFO_WIDTH,
  parameter int IMG_W     = definitions_pkg::IMG_W,
  parameter int IMG_H     = definitions_pkg::IMG_H,
  parameter int FLUSH_MAX = 2 * IMG_W + 16
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] pix_in,
  output logic              pix_in_valid,
  input  logic [DATA_W-1:0] pix_out,
  input  logic              pix_out_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr,
  input  logic              tx_full,
  output logic              kernel_select,
  output logic [1:0]        fill_select,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        err,
  input  logic              err_clr
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int FL_W  = $clog2(FLUSH_MAX + 1);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [FL_W-1:0]  FLUSH_C = FL_W'(FLUSH_MAX);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [DATA_W-1:0] pix_in_q, pix_in_d;
  logic              pix_in_valid_q, pix_in_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_wr_q, tx_wr_d;
  logic              kernel_q, kernel_d;
  logic [1:0]        fill_q, fill_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [2:0]        err_q, err_d;
  logic              out_done;
  logic              timeout;

  always_comb begin
    state_d        = state_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    kernel_d       = kernel_q;
    fill_d         = fill_q;
    pix_in_d       = '0;
    pix_in_valid_d = 1'b0;
    tx_data_d      = tx_data_q;
    tx_wr_d        = 1'b0;
    frame_done_d   = 1'b0;
    err_d          = err_clr ? '0 : err_q;
    out_done       = 1'b0;
    timeout        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data[7:3] == CMD_SYNC)) begin
          kernel_d    = rx_data[0];
          fill_d      = rx_data[2:1];
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          flush_cnt_d = '0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD, S_FLUSH: begin
        if (state_q == S_LOAD) begin
          if (rx_valid) begin
            pix_in_d       = rx_data;
            pix_in_valid_d = 1'b1;
            in_cnt_d       = in_cnt_q + CNT_W'(1);
            if (in_cnt_d == TOTAL_C) state_d = S_FLUSH;
          end
        end else begin
          pix_in_valid_d = 1'b1;
          if (rx_valid) err_d[ERR_RX_DROP] = 1'b1;
          if (flush_cnt_q != FLUSH_C) flush_cnt_d = flush_cnt_q + FL_W'(1);
          timeout = (flush_cnt_d == FLUSH_C);
        end

        // A suppressed write still advances out_cnt so the frame stays aligned.
        if (pix_out_valid && (out_cnt_q < TOTAL_C)) begin
          out_cnt_d = out_cnt_q + CNT_W'(1);
          tx_data_d = pix_out;
          if (tx_full) err_d[ERR_TX_DROP] = 1'b1;
          else         tx_wr_d = 1'b1;
          out_done = (out_cnt_d == TOTAL_C);
        end

        if (out_done) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end else if (timeout) begin
          err_d[ERR_FLUSH_TO] = 1'b1;
          state_d             = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q        <= S_IDLE;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      flush_cnt_q    <= '0;
      pix_in_q       <= '0;
      pix_in_valid_q <= 1'b0;
      tx_data_q      <= '0;
      tx_wr_q        <= 1'b0;
      kernel_q       <= 1'b0;
      fill_q         <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      pix_in_q       <= pix_in_d;
      pix_in_valid_q <= pix_in_valid_d;
      tx_data_q      <= tx_data_d;
      tx_wr_q        <= tx_wr_d;
      kernel_q       <= kernel_d;
      fill_q         <= fill_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      err_q          <= err_d;
    end
  end

  assign pix_in        = pix_in_q;
  assign pix_in_valid  = pix_in_valid_q;
  assign tx_data       = tx_data_q;
  assign tx_wr         = tx_wr_q;
  assign kernel_select = kernel_q;
  assign fill_select   = fill_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on a 4x2 frame, with a 5-cycle model
// pipeline that returns each input pixel plus 0x40.
module tb_frame_sequencer;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] pix_in;
  logic       pix_in_valid;
  logic [7:0] pix_out;
  logic       pix_out_valid;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic       kernel_select;
  logic [1:0] fill_select;
  logic       busy;
  logic       frame_done;
  logic [2:0] err;
  logic       err_clr;
  logic       pipe_en;

  int vectors     = 0;
  int miscompares = 0;

  int         tx_cnt, fd_cnt, zc, cyc, fd_cyc;
  logic [7:0] tx_log [16];
  logic [8:0] pipe   [5];

  frame_sequencer #(
    .DATA_W   (8),
    .IMG_W    (4),
    .IMG_H    (2),
    .FLUSH_MAX(16)
  ) dut (
    .clk          (clk),
    .rstN         (rstN),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .pix_in       (pix_in),
    .pix_in_valid (pix_in_valid),
    .pix_out      (pix_out),
    .pix_out_valid(pix_out_valid),
    .tx_data      (tx_data),
    .tx_wr        (tx_wr),
    .tx_full      (tx_full),
    .kernel_select(kernel_select),
    .fill_select  (fill_select),
    .busy         (busy),
    .frame_done   (frame_done),
    .err          (err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < 5; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {pix_in_valid, pix_in};
      for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign pix_out_valid = pipe[4][8] & pipe_en;
  assign pix_out       = pipe[4][7:0] + 8'h40;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_wr) begin
      if (tx_cnt < 16) tx_log[tx_cnt] = tx_data;
      tx_cnt++;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (pix_in_valid && (pix_in == 8'h00)) zc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_tally();
    tx_cnt = 0; fd_cnt = 0; zc = 0; cyc = 0; fd_cyc = -1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      rx_data = base + 8'(i); rx_valid = 1'b1;
      step();
      chk("pix_in", {23'd0, pix_in_valid, pix_in}, {23'd1, 8'(base + 8'(i))});
    end
    rx_valid = 1'b0;
  endtask

  task automatic chk_log(input string tag, input logic [7:0] base, input int skip);
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (i != skip) begin
        chk(tag, tx_log[k], 8'(base + 8'(i) + 8'h40));
        k++;
      end
    end
  endtask

  initial begin
    rstN = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_full = 1'b0; err_clr = 1'b0; pipe_en = 1'b1;
    clr_tally();
    steps(2);
    chk("rst_pix", {pix_in_valid, pix_in}, 9'd0);
    chk("rst_tx", {tx_wr, tx_data}, 9'd0);
    chk("rst_cfg", {kernel_select, fill_select}, 3'd0);
    chk("rst_stat", {busy, frame_done, err}, 5'd0);
    rstN = 1'b1;
    steps(2);

    // Frame 1: normal frame, pipeline echoes; extra outputs after 8 are ignored.
    send_cmd(8'hA3);
    chk("f1_cfg", {busy, kernel_select, fill_select}, 4'b1101);
    clr_tally();
    send_pix(8'd1);
    step();
    chk("f1_first_zero", {pix_in_valid, pix_in}, 9'h100);
    steps(12);
    chk("f1_tx_cnt", tx_cnt, 8);
    chk("f1_fd_cnt", fd_cnt, 1);
    chk("f1_fd_cyc", fd_cyc, 14);
    chk("f1_zeros", zc, 6);
    chk("f1_end", {busy, err}, 4'd0);
    chk_log("f1_tx_data", 8'd1, -1);
    steps(8);

    // Non-command byte ignored, then 0xA0 with pipeline silent -> flush timeout.
    pipe_en = 1'b0;
    send_cmd(8'h55);
    chk("f2_ignore", {busy, kernel_select, fill_select}, 4'b0101);
    send_cmd(8'hA0);
    chk("f2_cfg", {busy, kernel_select, fill_select}, 4'b1000);
    clr_tally();
    send_pix(8'd11);
    rx_data = 8'h77; rx_valid = 1'b1; err_clr = 1'b1;
    step();
    rx_valid = 1'b0; err_clr = 1'b0;
    chk("f2_rxdrop_set_wins", err, 3'b001);
    steps(14);
    chk("f2_busy_before_to", busy, 1);
    step();
    chk("f2_timeout", {busy, err}, 4'b0011);
    chk("f2_zeros", zc, 16);
    steps(3);
    chk("f2_no_done", fd_cnt, 0);
    chk("f2_no_tx", tx_cnt, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("f2_err_clr", err, 3'd0);
    steps(8);

    // Frame 3: tx_full during output 3.
    pipe_en = 1'b1;
    send_cmd(8'hA5);
    chk("f3_cfg", {kernel_select, fill_select}, 3'b110);
    clr_tally();
    send_pix(8'd31);
    tx_full = 1'b1;
    step();
    tx_full = 1'b0;
    chk("f3_txfull_err", {tx_wr, err}, 4'b0100);
    steps(12);
    chk("f3_tx_cnt", tx_cnt, 7);
    chk("f3_fd_cnt", fd_cnt, 1);
    chk("f3_fd_cyc", fd_cyc, 14);
    chk_log("f3_tx_data", 8'd31, 2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("f3_err_clr", err, 3'd0);
    steps(8);

    // Reset during pixel 5 of LOAD, then a normal 0xA1 frame.
    send_cmd(8'hA3);
    for (int i = 1; i <= 4; i++) begin
      rx_data = 8'(i); rx_valid = 1'b1;
      step();
    end
    rx_data = 8'd5; rstN = 1'b0;
    step();
    rx_valid = 1'b0;
    chk("r_pix", {pix_in_valid, pix_in}, 9'd0);
    chk("r_tx", {tx_wr, tx_data}, 9'd0);
    chk("r_cfg", {kernel_select, fill_select}, 3'd0);
    chk("r_stat", {busy, frame_done, err}, 5'd0);
    rstN = 1'b1;
    steps(8);
    send_cmd(8'hA1);
    chk("f4_cfg", {busy, kernel_select, fill_select}, 4'b1100);
    clr_tally();
    send_pix(8'd21);
    steps(13);
    chk("f4_tx_cnt", tx_cnt, 8);
    chk("f4_fd_cnt", fd_cnt, 1);
    chk("f4_end", {busy, err}, 4'd0);
    chk_log("f4_tx_data", 8'd21, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame-level controller between the UART byte stream and the `canny_edge_top` pixel pipeline. It decodes a per-frame command byte into the `kernel_select`/`fill_select` configuration and forwards exactly IMG_W*IMG_H pixels into the pipeline. It then injects zero pixels to flush the pipeline, and forwards exactly IMG_W*IMG_H result pixels to the UART TX FIFO. It sits inside `chip_top` between `uart_top` and `canny_edge_top` and owns all frame framing and error reporting.

## Interface
Parameters:
- DATA_W, FIFO_WIDTH: byte/pixel width.
- IMG_W, 64: pixels per line.
- IMG_H, 64: lines per frame.
- FLUSH_MAX, 2*IMG_W+16: maximum zero pixels injected before timeout.

Ports:
- clk  in  1  single clock for the whole block.
- rstN  in  1  reset. Synchronous, active-low.
- rx_data  in  DATA_W  byte from the UART RX FIFO.
- rx_valid  in  1  rx_data valid this cycle.
- pix_in  out  DATA_W  pixel to the pipeline.
- pix_in_valid  out  1  pix_in valid.
- pix_out  in  DATA_W  pixel from the pipeline.
- pix_out_valid  in  1  pix_out valid.
- tx_data  out  DATA_W  byte to the UART TX FIFO.
- tx_wr  out  1  TX FIFO write strobe.
- tx_full  in  1  TX FIFO full.
- kernel_select  out  1  pipeline kernel config.
- fill_select  out  2  pipeline border-fill config.
- busy  out  1  high when the state is not IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.
- err  out  3  sticky flags: [0] rx byte dropped during FLUSH, [1] flush timeout, [2] TX write dropped because tx_full.
- err_clr  in  1  clears err.

## Operation
- State machine: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - A byte with rx_data[7:3] == 5'b10100 is a command. It latches kernel_select = rx_data[0] and fill_select = rx_data[2:1], clears in_cnt, out_cnt and flush_cnt, then goes to LOAD.
  - Any other byte is ignored.
  - pix_out_valid is ignored; no count, no tx_wr.
- LOAD:
  - Each rx_valid byte is forwarded as pix_in with pix_in_valid, and in_cnt increments.
  - When the byte that makes in_cnt == IMG_W*IMG_H is accepted, go to FLUSH.
- FLUSH:
  - Drive pix_in = 0 with pix_in_valid = 1 every cycle, and increment flush_cnt.
  - Bytes arriving on rx_valid are dropped and set err[0].
  - If flush_cnt reaches FLUSH_MAX before the output count completes, set err[1] and go to IDLE with no frame_done.
- Output path, in LOAD and FLUSH:
  - Each pix_out_valid with out_cnt < TOTAL is written as tx_data/tx_wr, and out_cnt increments.
  - Pixels with out_cnt >= TOTAL are discarded.
  - If tx_full is high, the write is suppressed, err[2] is set, and out_cnt still increments so framing is preserved.
- Completion: when out_cnt reaches TOTAL, go to DONE. DONE pulses frame_done for one cycle, then goes to IDLE.
- Completion takes priority over timeout in the same cycle.
- err is cleared by err_clr. A set condition wins over err_clr in the same cycle.
- kernel_select and fill_select hold their values until the next command byte.

## Timing
- Reset value of every output and register is 0: pix_in, pix_in_valid, tx_data, tx_wr, kernel_select, fill_select, busy, frame_done, err, and all counters. The state resets to IDLE.
- Reset asserted mid-frame aborts the frame on that edge; nothing is flushed.
- All outputs are registered.
- rx_valid to pix_in_valid: 1-cycle latency.
- pix_out_valid to tx_wr: 1-cycle latency.
- The command byte takes effect on kernel_select/fill_select one cycle after it is accepted.
- The first pixel may arrive in the cycle immediately after the command byte.
- The LOAD-to-FLUSH transition occurs on the edge that accepts the last pixel. The first zero pixel appears on pix_in one cycle later.
- frame_done is high in the cycle after out_cnt reaches TOTAL. busy falls in the following cycle.
- Counter widths: $clog2(IMG_W*IMG_H+1) for in_cnt and out_cnt, $clog2(FLUSH_MAX+1) for flush_cnt. No counter wraps.
- With no backpressure from the pipeline, pixels can be accepted every cycle.

## Structure
- `definitions_pkg`: add IMG_W, IMG_H, TOTAL_PIX, CMD_SYNC (5'b10100), FLUSH_MAX, the `seq_state_t` enum, and err bit index constants. Reuse FIFO_WIDTH.
- Single module, no sub-modules; the counters are simple enough to keep inline.
- `chip_top` instantiates it between `uart_top` and `canny_edge_top`. Its kernel_select and fill_select outputs replace the current test inputs.

## Test plan
Use IMG_W=4, IMG_H=2 (TOTAL=8) and FLUSH_MAX=16, with a model pipeline of 5-cycle latency.
- Send 0xA3, then pixels 1..8 -> kernel_select=1 and fill_select=01 one cycle after the command; pix_in shows 1..8 then zeros; exactly 8 tx_wr; one frame_done pulse; err=0.
- Send 0x55, then 0xA0 -> 0x55 ignored (busy stays 0); 0xA0 starts LOAD with kernel_select=0 and fill_select=00.
- Model pipeline that never outputs -> after 16 zero pixels, err[1]=1 and the state returns to IDLE; no frame_done.
- Model pipeline emits 10 pixels -> only the first 8 reach tx_wr; the extra 2 are dropped with no error.
- Hold tx_full=1 during output 3 -> that write is suppressed, err[2]=1, the frame still completes after 8 outputs; err_clr then clears err to 0.
- rstN low during pixel 5 of LOAD -> on the next edge all outputs are 0 and the state is IDLE; a following 0xA1 frame completes normally.
